// File: rtl/snn_inference_scheduler.sv
// snn_inference_scheduler
// Runs one inference of the two-layer spiking network for each accepted input
// word. The sequence is: clear the network state, step it a fixed number of
// timesteps, count layer-2 spikes per output neuron, then pick the winner with
// a sequential argmax and present it on a valid/ready result port.
//
// Ports:
//   clk, reset             - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      - input word handshake (ready only while idle)
//   in_data                - input word, latched on accept
//   net_input              - latched word, held for the whole inference
//   net_clear / net_step   - network clear level and one-cycle step pulses
//   spike_in               - layer-2 spikes, valid the cycle after each step
//   res_valid/res_ready    - result handshake
//   res_class/res_count    - winning neuron index and its spike count
//   res_none               - every counter was zero
//   busy                   - high in every state except idle
module snn_inference_scheduler #(
  parameter int DATA_W       = 16,
  parameter int NUM_OUT      = 5,
  parameter int NUM_STEPS    = 8,
  parameter int CLEAR_CYCLES = 2,
  parameter int CNT_W        = 4,
  parameter int CLS_W        = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic [DATA_W-1:0]  net_input,
  output logic               net_clear,
  output logic               net_step,
  input  logic [NUM_OUT-1:0] spike_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CLS_W-1:0]   res_class,
  output logic [CNT_W-1:0]   res_count,
  output logic               res_none,
  output logic               busy
);

  localparam int PH_MAX = (NUM_STEPS > CLEAR_CYCLES) ? NUM_STEPS : CLEAR_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_ARGMAX,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [PH_W-1:0]   r_phase;
  logic [CLS_W-1:0]  r_scan;
  logic              r_step_d;
  logic [CNT_W-1:0]  r_cnt [NUM_OUT];
  logic [CLS_W-1:0]  r_best_idx;
  logic [CNT_W-1:0]  r_best_cnt;

  logic [DATA_W-1:0] r_net_input;
  logic              r_net_clear;
  logic              r_net_step;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_res_valid;
  logic [CLS_W-1:0]  r_res_class;
  logic [CNT_W-1:0]  r_res_count;
  logic              r_res_none;

  logic [CNT_W-1:0]  w_scan_cnt;
  logic [CLS_W-1:0]  w_nbest_idx;
  logic [CNT_W-1:0]  w_nbest_cnt;

  // One argmax step: index 0 seeds the running best; later indices replace it
  // only on a strictly greater count, so ties keep the lowest index.
  always_comb begin
    w_scan_cnt  = r_cnt[r_scan];
    w_nbest_idx = r_best_idx;
    w_nbest_cnt = r_best_cnt;
    if (r_scan == '0 || w_scan_cnt > r_best_cnt) begin
      w_nbest_idx = r_scan;
      w_nbest_cnt = w_scan_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_scan      <= '0;
      r_step_d    <= 1'b0;
      r_best_idx  <= '0;
      r_best_cnt  <= '0;
      r_net_input <= '0;
      r_net_clear <= 1'b0;
      r_net_step  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_class <= '0;
      r_res_count <= '0;
      r_res_none  <= 1'b0;
      for (int unsigned i = 0; i < NUM_OUT; i++) r_cnt[i] <= '0;
    end else begin
      r_step_d <= r_net_step;

      // Spikes answer the previous step pulse; counters saturate at all-ones.
      if (r_step_d) begin
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
          if (spike_in[i] && r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_net_input <= in_data;
            r_phase     <= '0;
            r_scan      <= '0;
            r_net_clear <= 1'b1;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_CLEAR;
            for (int unsigned i = 0; i < NUM_OUT; i++) r_cnt[i] <= '0;
          end
        end
        S_CLEAR: begin
          if (r_phase == PH_W'(CLEAR_CYCLES - 1)) begin
            r_net_clear <= 1'b0;
            r_net_step  <= 1'b1;
            r_phase     <= '0;
            r_state     <= S_RUN;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_RUN: begin
          if (r_phase == PH_W'(NUM_STEPS - 1)) begin
            r_net_step <= 1'b0;
            r_state    <= S_DRAIN;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_DRAIN: begin
          r_scan  <= '0;
          r_state <= S_ARGMAX;
        end
        S_ARGMAX: begin
          r_best_idx <= w_nbest_idx;
          r_best_cnt <= w_nbest_cnt;
          // The final scan step writes the result directly so it is visible
          // in the first DONE cycle.
          if (r_scan == CLS_W'(NUM_OUT - 1)) begin
            r_res_class <= w_nbest_idx;
            r_res_count <= w_nbest_cnt;
            r_res_none  <= (w_nbest_cnt == '0);
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_scan <= r_scan + 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign net_input = r_net_input;
  assign net_clear = r_net_clear;
  assign net_step  = r_net_step;
  assign res_valid = r_res_valid;
  assign res_class = r_res_class;
  assign res_count = r_res_count;
  assign res_none  = r_res_none;

endmodule

// File: tb/tb_snn_inference_scheduler.sv
module tb_snn_inference_scheduler;
  localparam int DW  = 16;
  localparam int N   = 5;
  localparam int S   = 8;
  localparam int C   = 2;
  localparam int CW  = 4;
  localparam int SS  = 20;
  localparam int LAT = 1 + C + S + 1 + N;
  localparam int SLAT = 1 + C + SS + 1 + N;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, res_ready = 1'b0;
  logic s_in_valid = 1'b0, s_res_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [N-1:0]  spike_in = '0;

  logic in_ready, net_clear, net_step, res_valid, res_none, busy;
  logic [DW-1:0] net_input;
  logic [2:0] res_class;
  logic [CW-1:0] res_count;

  logic s_in_ready, s_net_clear, s_net_step, s_res_valid, s_res_none, s_busy;
  logic [DW-1:0] s_net_input;
  logic [2:0] s_res_class;
  logic [CW-1:0] s_res_count;

  always #5 clk = ~clk;

  snn_inference_scheduler u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .net_input(net_input), .net_clear(net_clear),
    .net_step(net_step), .spike_in(spike_in), .res_valid(res_valid),
    .res_ready(res_ready), .res_class(res_class), .res_count(res_count),
    .res_none(res_none), .busy(busy)
  );

  snn_inference_scheduler #(.NUM_STEPS(SS)) u_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .net_input(s_net_input), .net_clear(s_net_clear),
    .net_step(s_net_step), .spike_in(spike_in), .res_valid(s_res_valid),
    .res_ready(s_res_ready), .res_class(s_res_class), .res_count(s_res_count),
    .res_none(s_res_none), .busy(s_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: m_t is the index of the current cycle since the accept
  // (accept cycle = 0). Outputs follow directly from that index.
  bit          m_act = 0;
  int          m_t = 0;
  logic [DW-1:0] m_in = '0;
  int          m_cnt [N];
  bit          m_rv = 0;
  int          m_cls = 0, m_rc = 0;
  bit          m_none = 0;

  always @(posedge clk) begin
    int best;
    if (reset) begin
      m_act = 0; m_t = 0; m_in = '0; m_rv = 0; m_cls = 0; m_rc = 0; m_none = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else if (!m_act) begin
      if (in_valid) begin
        m_act = 1; m_t = 1; m_in = in_data;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end
    end else if (m_rv) begin
      if (res_ready) begin
        m_rv = 0; m_act = 0;
      end
    end else begin
      if (m_t >= C + 2 && m_t <= C + S + 1)
        for (int i = 0; i < N; i++)
          if (spike_in[i] && m_cnt[i] < CMAX) m_cnt[i]++;
      if (m_t == LAT - 1) begin
        best = 0;
        for (int i = 1; i < N; i++) if (m_cnt[i] > m_cnt[best]) best = i;
        m_cls = best; m_rc = m_cnt[best]; m_none = (m_rc == 0); m_rv = 1;
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  in_ready,  !m_act);
    chk("busy",      busy,      m_act);
    chk("net_input", net_input, m_in);
    chk("net_clear", net_clear, m_act && m_t >= 1 && m_t <= C);
    chk("net_step",  net_step,  m_act && m_t >= C + 1 && m_t <= C + S);
    chk("res_valid", res_valid, m_rv);
    chk("res_class", res_class, m_cls);
    chk("res_count", res_count, m_rc);
    chk("res_none",  res_none,  m_none);
    chk("clear_step_excl", net_clear && net_step, 0);
  end

  // Spike driver: 0 random, 1 constant pattern, 2 pattern with bit 4 dropped
  // for the first counted step.
  int sp_mode = 0;
  logic [N-1:0] sp_pat = '0;
  always @(negedge clk) begin
    case (sp_mode)
      1: spike_in = sp_pat;
      2: spike_in = (m_t == C + 2) ? (sp_pat & 5'b01111) : sp_pat;
      default: spike_in = N'($urandom);
    endcase
  end

  task automatic run_inf(input logic [DW-1:0] d, input logic [2:0] ecls,
                         input logic [CW-1:0] ecnt, input logic enone,
                         input int hold, input bit glitch);
    int t;
    @(negedge clk); in_valid = 1'b1; in_data = d; res_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0; in_data = DW'($urandom);
    t = 1;
    chk("lit_clear_c1", net_clear, 1);
    while (!res_valid && t < 100) begin
      if (t == C + 1) chk("lit_step_first", net_step, 1);
      if (t == 8) chk("lit_net_input", net_input, d);
      if (glitch && t == 6) begin in_valid = 1'b1; in_data = 16'hFFFF; end
      else in_valid = 1'b0;
      @(negedge clk); t++;
    end
    in_valid = 1'b0;
    chk("lit_latency", t, LAT);
    for (int k = 0; k < hold; k++) begin
      chk("lit_hold_valid", res_valid, 1);
      chk("lit_hold_class", res_class, ecls);
      chk("lit_hold_ready", in_ready, 0);
      @(negedge clk);
    end
    chk("lit_res_class", res_class, ecls);
    chk("lit_res_count", res_count, ecnt);
    chk("lit_res_none",  res_none,  enone);
    chk("lit_net_input_end", net_input, d);
    res_ready = 1'b1;
    @(negedge clk); res_ready = 1'b0;
    chk("lit_ready_after", in_ready, 1);
    chk("lit_valid_after", res_valid, 0);
    chk("lit_class_kept", res_class, ecls);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("lit_rst_in_ready", in_ready, 1);
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_valid", res_valid, 0);
    chk("lit_rst_step", net_step, 0);
    chk("lit_rst_clear", net_clear, 0);
    chk("lit_rst_input", net_input, 0);
    reset = 1'b0;

    sp_mode = 1; sp_pat = 5'b00100;
    run_inf(16'hAAAA, 3'd2, 4'd8, 1'b0, 10, 1'b1);

    sp_mode = 2; sp_pat = 5'b11010;
    run_inf(16'h1234, 3'd1, 4'd8, 1'b0, 0, 1'b0);

    sp_mode = 1; sp_pat = 5'b00000;
    run_inf(16'h0F0F, 3'd0, 4'd0, 1'b1, 2, 1'b0);

    // Saturation on the 20-step instance.
    sp_mode = 1; sp_pat = 5'b00001;
    @(negedge clk); s_in_valid = 1'b1;
    @(negedge clk); s_in_valid = 1'b0;
    t = 1;
    while (!s_res_valid && t < 100) begin @(negedge clk); t++; end
    chk("lit_sat_latency", t, SLAT);
    chk("lit_sat_count", s_res_count, 15);
    chk("lit_sat_class", s_res_class, 0);
    chk("lit_sat_none", s_res_none, 0);
    s_res_ready = 1'b1;
    @(negedge clk); s_res_ready = 1'b0;
    chk("lit_sat_idle", s_in_ready, 1);

    // Reset during the 5th step pulse.
    sp_mode = 0;
    @(negedge clk); in_valid = 1'b1; in_data = 16'h5A5A;
    @(negedge clk); in_valid = 1'b0;
    for (int k = 1; k < 7; k++) @(negedge clk);
    chk("lit_rst_mid_step", net_step, 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("lit_after_rst_step", net_step, 0);
    chk("lit_after_rst_ready", in_ready, 1);
    chk("lit_after_rst_busy", busy, 0);
    for (int k = 0; k < 25; k++) begin
      chk("lit_after_rst_novalid", res_valid, 0);
      @(negedge clk);
    end

    // Randomized traffic, checked against the model every cycle.
    for (int k = 0; k < 1500; k++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      in_data   = DW'($urandom);
      res_ready = ($urandom_range(0, 2) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/snn_inference_scheduler.md
Name: snn_inference_scheduler

Overview:
Sequences one inference of the two-layer spiking fully-connected network per input sample. It accepts a 16-bit input word (from the SPI front end) through a valid/ready handshake and drives it as the network's current input. It clears the network state, steps the network for a fixed number of timesteps, and counts layer-2 spikes per output neuron. It then resolves the winning class by sequential argmax and presents it on a valid/ready result port.

Parameters:
DATA_W, 16, width of input word / network current input
NUM_OUT, 5, number of layer-2 output neurons counted
NUM_STEPS, 8, network timesteps per inference (>=1)
CLEAR_CYCLES, 2, cycles net_clear is held before stepping (>=1)
CNT_W, 4, width of each per-neuron spike counter (saturating)
CLS_W, 3, width of class index; NUM_OUT <= 2**CLS_W

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  input word available
in_ready  output  1  scheduler can accept a word (IDLE only)
in_data  input  DATA_W  input word
net_input  output  DATA_W  current input driven to network, held stable for whole inference
net_clear  output  1  clears network membrane/refractory state
net_step  output  1  one-cycle pulse = advance network one timestep
spike_in  input  NUM_OUT  layer-2 spike vector from network
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_class  output  CLS_W  winning neuron index
res_count  output  CNT_W  spike count of winner
res_none  output  1  1 when every count is zero
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (sync, active-high, overrides everything): state=IDLE; in_ready=1; net_input=0, net_clear=0, net_step=0, res_valid=0, res_class=0, res_count=0, res_none=0, busy=0; all counters=0.
- Reset mid-operation: next cycle is IDLE with the reset values above. No result is produced and no net_step issues after reset.
- States: IDLE -> CLEAR -> RUN -> DRAIN -> ARGMAX -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready: net_input<=in_data, spike counters<=0, step/scan counters<=0, go to CLEAR.
- All other states: in_ready=0. in_valid is ignored; no data is latched.
- CLEAR: net_clear=1 for exactly CLEAR_CYCLES cycles, then RUN.
- RUN: net_step=1 every cycle for exactly NUM_STEPS cycles, then DRAIN.
- Network latency is one cycle: spike_in is valid in the cycle after each net_step pulse. The block keeps step_d = net_step registered.
- Counting: in any cycle with step_d=1, count[i] <= count[i] + spike_in[i] for each i. Counters saturate at 2**CNT_W-1 and never wrap. spike_in is ignored when step_d=0.
- DRAIN: one cycle that samples the final step's spikes (step_d=1 here). Then ARGMAX.
- ARGMAX: scans one neuron per cycle, index 0..NUM_OUT-1, for NUM_OUT cycles. It keeps best_idx/best_cnt. best_idx is replaced only on strictly greater count, so ties resolve to the lowest index. Scan starts with best_idx=0, best_cnt=count[0].
- DONE: register res_class=best_idx, res_count=best_cnt, res_none=(best_cnt==0). res_valid=1.
- res_valid and res_* stay stable until res_ready. On res_valid&&res_ready, the next cycle is IDLE with res_valid=0 and in_ready=1.
- Results are not accepted and inputs are not accepted in the same cycle. The earliest next accept is the cycle after the result handshake.
- res_class/res_count/res_none keep their last values after the handshake until the next DONE.
- Latency: input accepted in cycle 0 -> net_clear in cycles 1..CLEAR_CYCLES -> net_step in the next NUM_STEPS cycles -> res_valid first high in cycle 1+CLEAR_CYCLES+NUM_STEPS+1+NUM_OUT. Defaults: 17.
- net_clear and net_step are never high in the same cycle.

Test Plan:
- Reset then idle: assert reset 3 cycles -> in_ready=1, busy=0, res_valid=0, net_step=0, net_clear=0, net_input=0.
- Single inference: accept in_data=16'hAAAA at cycle 0; spike_in=5'b00100 whenever step_d=1 -> net_clear in cycles 1-2, net_step in 3-10, res_valid in cycle 17, res_class=2, res_count=8, res_none=0, net_input=16'hAAAA throughout.
- Tie and partial: neuron 1 and neuron 3 spike on all 8 steps, neuron 4 on 7 -> res_class=1, res_count=8.
- No activity: spike_in=0 always -> res_class=0, res_count=0, res_none=1.
- Saturation: NUM_STEPS=20, CNT_W=4, neuron 0 spikes every step -> res_count=15 (no wrap), res_class=0.
- Backpressure/robustness: hold res_ready=0 for 10 cycles -> res_* stable, in_ready=0. Pulse in_valid=1 with in_data=16'hFFFF during RUN -> ignored, net_input unchanged. Separate run: assert reset at the 5th net_step cycle -> next cycle IDLE, net_step=0, in_ready=1, and no res_valid.
